apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- APB4 completer that sits directly behind the team's APB slave interface and is the DUT that interface drives.
- Provides a byte-strobed word memory with a programmable number of wait states.
- Flags misaligned, out-of-range and malformed transfers through PSLVERR.
- Single clock domain. No other bus ports.

Parameters:
ADDR_W, 9, PADDR width (byte address)
DATA_W, 32, data width; PSTRB width = DATA_W/8
MEM_DEPTH, 64, number of words; valid byte addresses 0x000–0x0FC
WAIT_CYCLES, 1, PREADY-low cycles inserted at the start of each access phase (0 allowed)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  synchronous, active-high reset
PSEL  in  1  select
PENABLE  in  1  access-phase strobe
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_W  byte address
PWDATA  in  DATA_W  write data
PSTRB  in  DATA_W/8  write byte lanes
PRDATA  out  DATA_W  read data
PREADY  out  1  transfer completes when high in access phase
PSLVERR  out  1  error response, qualified by PREADY

Behaviour:
- Clocking and reset: one clock PCLK. Reset PRESET is synchronous and active-high.
- Reset values:
  - FSM=IDLE.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - All memory words=0, except word 63, which resets to ID_WORD=32'hA9B5_0100.
- FSM states: IDLE, WAIT, READY. All outputs are registered.
- IDLE:
  - On sampling PSEL=1, PENABLE=0 (setup phase), capture PADDR, PWRITE, PWDATA, PSTRB and the error decision.
  - Then go to WAIT with cnt=WAIT_CYCLES, or go directly to READY when WAIT_CYCLES=0.
  - PSEL=1 with PENABLE=1 seen in IDLE (no setup) is ignored; remain in IDLE.
- WAIT:
  - PREADY=0. Decrement cnt each cycle.
  - When cnt reaches 1, the next state is READY.
  - Access-phase PREADY rises in access cycle WAIT_CYCLES+1 after setup.
- READY:
  - PREADY=1, PSLVERR=err, PRDATA=read word or 0.
  - On completion (PSEL & PENABLE & PREADY):
    - Perform the write if there is no error.
    - Drop PREADY, PSLVERR and PRDATA to 0 on that edge and return to IDLE.
  - A back-to-back setup in the following cycle is accepted.
- Error conditions (err=1):
  - PADDR[1:0]≠0.
  - Word index ≥ MEM_DEPTH.
  - Read with PSTRB≠0.
- On error: writes do not modify memory; reads return PRDATA=0.
- Write strobes: PSTRB=0 on a write is legal; no byte is modified and there is no error.
- Byte lane i is written only when PSTRB[i]=1.
- Address and data are used as captured at setup; changes during the access phase are ignored.
- Abort: PSEL=0 in WAIT or READY before completion → go to IDLE, drive outputs 0, no write.
- Reset mid-transfer: everything returns to reset values and the pending write is discarded.
- PRDATA and PSLVERR are 0 whenever PREADY=0.

Optional Feature:
- Macro: APB_SLV_RO_REGION_EN.
- Defined:
  - Words 60–63 (0x0F0–0x0FC) are read-only.
  - Writes to them complete with PSLVERR=1 and no update.
  - Reads are normal.
- Undefined: these words are ordinary RW; word 63 still resets to ID_WORD.

Decomposition:
- Package apb_slave_pkg holds:
  - state_t enum (IDLE/WAIT/READY).
  - ADDR_W and DATA_W defaults.
  - ID_WORD.
  - RO_BASE_WORD=60.
  - The err-decode function.
- Sub-module apb_slave_mem_array:
  - Synchronous-reset word array.
  - Byte-enable write port.
  - Asynchronous read of the captured index.
  - Instantiated once.

Test Plan:
1. WAIT_CYCLES=1: write 0xDEADBEEF to 0x010 with PSTRB=4'hF, then read 0x010 → PREADY low 1 cycle then high; PRDATA=0xDEADBEEF, PSLVERR=0.
2. Write 0x11223344 with PSTRB=4'b0101 over 0xFFFFFFFF at 0x020, then read → PRDATA=0xFF22FF44.
3. Write to 0x013 (misaligned), then to 0x100 (out of range), then read 0x100 → each has PSLVERR=1; read PRDATA=0; memory unchanged.
4. WAIT_CYCLES=0, back-to-back reads of 0x0FC then 0x000 after reset → PREADY high in first access cycle; data 0xA9B50100 then 0x0.
5. Assert PRESET during WAIT of a write to 0x040 → PREADY=0 next cycle; later read of 0x040 returns 0.
6. With APB_SLV_RO_REGION_EN defined, write 0x0 to 0x0FC → PSLVERR=1; read returns 0xA9B50100. Undefined: same write → PSLVERR=0; read returns 0.

Source files
------------

// File: rtl/apb_slave_mem_pkg.sv
// apb_slave_pkg: shared types, defaults and error decode for the APB slave memory
package apb_slave_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] ID_WORD = 32'hA9B5_0100;
  localparam int ID_WORD_IDX = 63;
  localparam int RO_BASE_WORD = 60;
  function automatic logic err_decode(input logic misaligned, input logic out_of_range,
                                      input logic wr, input logic strb_any, input logic ro_hit);
    return misaligned | out_of_range | (!wr & strb_any) | (wr & ro_hit);
  endfunction
endpackage

// File: rtl/apb_slave_mem_array.sv
// apb_slave_mem_array: sync-reset word array with byte-enable write and async read
module apb_slave_mem_array
  import apb_slave_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = DATA_W_DEF,
  parameter int IW     = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [IW-1:0]       i_idx,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_strb,
  output logic [DATA_W-1:0]   o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= (k == ID_WORD_IDX) ? DATA_W'(ID_WORD) : '0;
    end else if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) if (i_strb[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end
  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer over a byte-strobed word memory with programmable wait states.
// Define APB_SLV_RO_REGION_EN to make words RO_BASE_WORD..63 read-only.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int SW = DATA_W/8;
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES + 1) : 1;
  state_t r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_idx, w_idx;
  logic [ADDR_W-3:0] w_aidx;
  logic [DATA_W-1:0] r_wdata, r_rdata, w_mem_rd;
  logic [SW-1:0] r_strb;
  logic r_write, r_err, r_ready, r_slverr;
  logic w_ro, w_err_in, w_cap, w_we, w_cur_err, w_cur_wr, w_ready_nxt;
  assign w_aidx = PADDR[ADDR_W-1:2];
`ifdef APB_SLV_RO_REGION_EN
  assign w_ro = 32'(w_aidx) >= 32'(RO_BASE_WORD);
`else
  assign w_ro = 1'b0;
`endif
  assign w_err_in = err_decode(PADDR[1:0] != 2'b00, 32'(w_aidx) >= 32'(MEM_DEPTH), PWRITE, |PSTRB, w_ro);
  // With zero wait states READY is entered straight from setup, so look at the live address there
  assign w_idx       = r_state == IDLE ? w_aidx[IW-1:0] : r_idx;
  assign w_cur_err   = r_state == IDLE ? w_err_in : r_err;
  assign w_cur_wr    = r_state == IDLE ? PWRITE : r_write;
  assign w_ready_nxt = w_nxt == READY;
  always_comb begin
    w_nxt = r_state;
    w_cnt_nxt = r_cnt;
    w_cap = 1'b0;
    w_we = 1'b0;
    unique case (r_state)
      IDLE: if (PSEL && !PENABLE) begin
        w_cap = 1'b1;
        w_nxt = WAIT_CYCLES == 0 ? READY : WAIT;
        w_cnt_nxt = CW'(WAIT_CYCLES);
      end
      WAIT: begin
        w_nxt = !PSEL ? IDLE : (r_cnt == CW'(1) ? READY : WAIT);
        w_cnt_nxt = r_cnt - 1'b1;
      end
      READY: if (!PSEL || PENABLE) begin
        w_nxt = IDLE;
        w_we = PSEL && r_write && !r_err;
      end
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ready  <= w_ready_nxt;
      r_slverr <= w_ready_nxt & w_cur_err;
      r_rdata  <= (w_ready_nxt && !w_cur_wr && !w_cur_err) ? w_mem_rd : '0;
      if (w_cap) begin
        r_idx   <= w_aidx[IW-1:0];
        r_write <= PWRITE;
        r_err   <= w_err_in;
        r_wdata <= PWDATA;
        r_strb  <= PSTRB;
      end
    end
  end
  apb_slave_mem_array #(.DEPTH(MEM_DEPTH), .DATA_W(DATA_W), .IW(IW)) u_mem (
    .i_clk(PCLK),
    .i_rst(PRESET),
    .i_we(w_we),
    .i_idx(w_idx),
    .i_wdata(r_wdata),
    .i_strb(r_strb),
    .o_rdata(w_mem_rd)
  );
  assign PREADY  = r_ready;
  assign PSLVERR = r_slverr;
  assign PRDATA  = r_rdata;
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed checks of two instances, one and zero wait states
module tb_apb_slave_mem;
  logic clk = 1'b0, preset = 1'b1;
  logic psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [8:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0] pstrb = '0;
  logic [31:0] prdata0, prdata1;
  logic pready0, pready1, pslverr0, pslverr1;
  int n_chk = 0, n_fail = 0;
`ifdef APB_SLV_RO_REGION_EN
  localparam logic RO_ERR = 1'b1;
  localparam logic [31:0] RO_DATA = 32'hA9B5_0100;
`else
  localparam logic RO_ERR = 1'b0;
  localparam logic [31:0] RO_DATA = 32'h0;
`endif
  always #5 clk = ~clk;
  apb_slave_mem #(.WAIT_CYCLES(0)) u_dut0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );
  apb_slave_mem #(.WAIT_CYCLES(1)) u_dut1 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic apb(input bit d, input bit wr, input logic [8:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic er, output int wt);
    if (d) psel1 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge clk);
    penable = 1'b1; paddr = a ^ 9'h0F0; pwdata = ~wd; wt = 0;
    while (!(d ? pready1 : pready0) && wt < 16) begin
      wt++;
      @(negedge clk);
    end
    chk("pready_seen", d ? pready1 : pready0, 1);
    rd = d ? prdata1 : prdata0;
    er = d ? pslverr1 : pslverr0;
    @(negedge clk);
    chk("pready_drop", d ? pready1 : pready0, 0);
    chk("prdata_drop", d ? prdata1 : prdata0, 0);
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask
  task automatic wr_chk(input bit d, input logic [8:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input logic exp_e, input int exp_w);
    logic [31:0] rd; logic er; int wt;
    apb(d, 1'b1, a, wd, st, rd, er, wt);
    chk("wr_err", er, exp_e);
    chk("wr_waits", wt, exp_w);
  endtask
  task automatic rd_chk(input bit d, input logic [8:0] a, input logic [3:0] st, input logic [31:0] exp_d,
                        input logic exp_e, input int exp_w);
    logic [31:0] rd; logic er; int wt;
    apb(d, 1'b0, a, 32'h0, st, rd, er, wt);
    chk("rd_data", rd, exp_d);
    chk("rd_err", er, exp_e);
    chk("rd_waits", wt, exp_w);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    preset = 1'b0;
    chk("rst_pready", {pready1, pready0}, 0);
    chk("rst_pslverr", {pslverr1, pslverr0}, 0);
    chk("rst_prdata", prdata1 | prdata0, 0);
    wr_chk(1, 9'h010, 32'hDEADBEEF, 4'hF, 0, 1);
    rd_chk(1, 9'h010, 4'h0, 32'hDEADBEEF, 0, 1);
    wr_chk(1, 9'h020, 32'hFFFFFFFF, 4'hF, 0, 1);
    wr_chk(1, 9'h020, 32'h11223344, 4'b0101, 0, 1);
    rd_chk(1, 9'h020, 4'h0, 32'hFF22FF44, 0, 1);
    wr_chk(1, 9'h013, 32'h0, 4'hF, 1, 1);
    wr_chk(1, 9'h100, 32'h0, 4'hF, 1, 1);
    rd_chk(1, 9'h100, 4'h0, 32'h0, 1, 1);
    rd_chk(1, 9'h010, 4'h0, 32'hDEADBEEF, 0, 1);
    rd_chk(1, 9'h010, 4'h1, 32'h0, 1, 1);
    wr_chk(1, 9'h010, 32'h0, 4'h0, 0, 1);
    rd_chk(1, 9'h010, 4'h0, 32'hDEADBEEF, 0, 1);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h010; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(negedge clk);
    psel1 = 1'b0;
    @(negedge clk);
    chk("abort_pready", pready1, 0);
    rd_chk(1, 9'h010, 4'h0, 32'hDEADBEEF, 0, 1);
    rd_chk(0, 9'h0FC, 4'h0, 32'hA9B50100, 0, 0);
    rd_chk(0, 9'h000, 4'h0, 32'h0, 0, 0);
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 9'h0FC; pstrb = 4'h0;
    @(negedge clk);
    chk("nosetup_pready", pready0, 0);
    psel0 = 1'b0; penable = 1'b0;
    @(negedge clk);
    wr_chk(0, 9'h0FC, 32'h0, 4'hF, RO_ERR, 0);
    rd_chk(0, 9'h0FC, 4'h0, RO_DATA, 0, 0);
    wr_chk(0, 9'h0EC, 32'h5A5A5A5A, 4'hF, 0, 0);
    rd_chk(0, 9'h0EC, 4'h0, 32'h5A5A5A5A, 0, 0);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h040; pwdata = 32'h12345678; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    chk("rstmid_wait", pready1, 0);
    preset = 1'b1;
    @(negedge clk);
    chk("rstmid_pready", pready1, 0);
    preset = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(negedge clk);
    rd_chk(1, 9'h040, 4'h0, 32'h0, 0, 1);
    rd_chk(1, 9'h010, 4'h0, 32'h0, 0, 1);
    rd_chk(1, 9'h0FC, 4'h0, 32'hA9B50100, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
